// File: rtl/mr_pkg.sv
// Shared definitions for the Miller-Rabin witness datapath.
//   - FSM state encodings (3-bit constants, also exported on the state debug port)
//   - modmul_latency(): cycles one modular product occupies a calling state
package mr_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_CHECK   = 3'd1;
    localparam logic [2:0] ST_DECOMP  = 3'd2;
    localparam logic [2:0] ST_EXP_SQ  = 3'd3;
    localparam logic [2:0] ST_EXP_MUL = 3'd4;
    localparam logic [2:0] ST_TEST    = 3'd5;
    localparam logic [2:0] ST_SQ_LOOP = 3'd6;
    localparam logic [2:0] ST_DONE    = 3'd7;

    // Registered start, BIT_LENGTH bit steps, one cycle to consume the result.
    function automatic int modmul_latency(input int bit_length);
        return bit_length + 2;
    endfunction

endpackage

// File: rtl/mod_mul_serial.sv
// Serial modular multiplier: result = (x_value * y_value) mod p_value.
// MSB-first double-and-add over y, one bit per cycle, with a conditional
// subtract after the doubling and after the addition so the accumulator
// always stays below p. Operands must already be < p.
// Ports:
//   aclk, areset        clock, synchronous active-high reset
//   start               pulse; operands captured when the unit is idle
//   x_value, y_value    multiplicand / multiplier (< p_value)
//   p_value             modulus
//   done                one-cycle pulse, result valid from then until next start
//   result              product mod p
module mod_mul_serial #(
    parameter int BIT_LENGTH = 128
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic                  start,
    input  logic [BIT_LENGTH-1:0] x_value,
    input  logic [BIT_LENGTH-1:0] y_value,
    input  logic [BIT_LENGTH-1:0] p_value,
    output logic                  done,
    output logic [BIT_LENGTH-1:0] result
);
    localparam int AW = BIT_LENGTH + 2;
    localparam int CW = $clog2(BIT_LENGTH);

    logic [AW-1:0]         acc;
    logic [BIT_LENGTH-1:0] x_r;
    logic [BIT_LENGTH-1:0] y_r;
    logic [BIT_LENGTH-1:0] p_r;
    logic [CW-1:0]         cnt;
    logic                  busy;

    logic [AW-1:0] p_ext;
    logic [AW-1:0] dbl;
    logic [AW-1:0] dbl_red;
    logic [AW-1:0] sum;
    logic [AW-1:0] acc_next;

    always_comb begin
        p_ext    = {2'b00, p_r};
        dbl      = {acc[AW-2:0], 1'b0};
        dbl_red  = (dbl >= p_ext) ? dbl - p_ext : dbl;
        sum      = y_r[cnt] ? dbl_red + {2'b00, x_r} : dbl_red;
        acc_next = (sum >= p_ext) ? sum - p_ext : sum;
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            acc  <= '0;
            x_r  <= '0;
            y_r  <= '0;
            p_r  <= '0;
            cnt  <= '0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start && !busy) begin
                x_r  <= x_value;
                y_r  <= y_value;
                p_r  <= p_value;
                acc  <= '0;
                cnt  <= CW'(BIT_LENGTH - 1);
                busy <= 1'b1;
            end else if (busy) begin
                acc <= acc_next;
                if (cnt == '0) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end else begin
                    cnt <= cnt - 1'b1;
                end
            end
        end
    end

    assign result = acc[BIT_LENGTH-1:0];

endmodule

// File: rtl/miller_rabin_witness.sv
// One Miller-Rabin round for a (p, a) pair: decompose p-1 = d*2^r, compute
// x = a^d mod p by MSB-first square-and-multiply, then up to r-1 squarings.
// Handshakes: a beat transfers on the rising edge where valid and ready are
// both high; the producer holds its payload stable while valid is high and
// not yet accepted. in_ready is high only in IDLE; out_valid only in DONE.
// Ports:
//   aclk, areset              clock, synchronous active-high reset
//   in_valid/in_ready         input handshake for p_value, a_value
//   out_valid/out_ready       output handshake for the verdict fields
//   probable_prime            p passes for base a
//   bad_witness               a outside [2, p-2], verdict meaningless
//   d_value, r_value          odd part of p-1 and its power of two
//   cycle_count               (MR_CYCLE_COUNT_EN only) accept-to-result cycles
//   state_dbg                 current FSM state (mr_pkg encodings)
// Optional feature macro: MR_CYCLE_COUNT_EN.
module miller_rabin_witness
    import mr_pkg::*;
#(
    parameter int BIT_LENGTH = 128,
    parameter int R_WIDTH    = $clog2(BIT_LENGTH) + 1
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BIT_LENGTH-1:0] p_value,
    input  logic [BIT_LENGTH-1:0] a_value,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  probable_prime,
    output logic                  bad_witness,
    output logic [BIT_LENGTH-1:0] d_value,
    output logic [R_WIDTH-1:0]    r_value,
`ifdef MR_CYCLE_COUNT_EN
    output logic [31:0]           cycle_count,
`endif
    output logic [2:0]            state_dbg
);
    localparam int PW = $clog2(BIT_LENGTH);
    localparam logic [BIT_LENGTH-1:0] ONE   = BIT_LENGTH'(1);
    localparam logic [BIT_LENGTH-1:0] TWO   = BIT_LENGTH'(2);
    localparam logic [BIT_LENGTH-1:0] THREE = BIT_LENGTH'(3);

    logic [2:0]            state;
    logic [BIT_LENGTH-1:0] p_r, a_r, x_r, d_r;
    logic [R_WIDTH-1:0]    r_r, k_r;
    logic [PW-1:0]         ptr, ptr_m1, d_msb;
    logic                  pp_r, bad_r;
    logic                  mul_start, mul_done;
    logic [BIT_LENGTH-1:0] mul_y, mul_res;
    logic [BIT_LENGTH-1:0] p_m1, p_m2;

    assign p_m1   = p_r - ONE;
    assign p_m2   = p_r - TWO;
    assign ptr_m1 = ptr - PW'(1);
    assign mul_y  = (state == ST_EXP_MUL) ? a_r : x_r;

    // MSB index of d; the MSB itself is absorbed by starting with x = a,
    // so the scan works on bits ptr-1 down to 0.
    always_comb begin
        d_msb = '0;
        for (int i = 0; i < BIT_LENGTH; i++) begin
            if (d_r[i]) d_msb = PW'(i);
        end
    end

    mod_mul_serial #(.BIT_LENGTH(BIT_LENGTH)) u_mul (
        .aclk    (aclk),
        .areset  (areset),
        .start   (mul_start),
        .x_value (x_r),
        .y_value (mul_y),
        .p_value (p_r),
        .done    (mul_done),
        .result  (mul_res)
    );

    always_ff @(posedge aclk) begin
        if (areset) begin
            state     <= ST_IDLE;
            p_r       <= '0;
            a_r       <= '0;
            x_r       <= '0;
            d_r       <= '0;
            r_r       <= '0;
            k_r       <= '0;
            ptr       <= '0;
            pp_r      <= 1'b0;
            bad_r     <= 1'b0;
            mul_start <= 1'b0;
        end else begin
            mul_start <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        p_r   <= p_value;
                        a_r   <= a_value;
                        pp_r  <= 1'b0;
                        bad_r <= 1'b0;
                        state <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    d_r   <= '0;
                    r_r   <= '0;
                    state <= ST_DONE;
                    if (p_r < TWO) begin
                        pp_r <= 1'b0;
                    end else if (p_r == TWO || p_r == THREE) begin
                        pp_r <= 1'b1;
                    end else if (!p_r[0]) begin
                        pp_r <= 1'b0;
                    end else if (a_r < TWO || a_r > p_m2) begin
                        bad_r <= 1'b1;
                    end else begin
                        d_r   <= p_m1;
                        state <= ST_DECOMP;
                    end
                end
                ST_DECOMP: begin
                    if (!d_r[0]) begin
                        d_r <= d_r >> 1;
                        r_r <= r_r + 1'b1;
                    end else begin
                        ptr <= d_msb;
                        x_r <= a_r;
                        if (d_r == ONE) begin
                            state <= ST_TEST;
                        end else begin
                            state     <= ST_EXP_SQ;
                            mul_start <= 1'b1;
                        end
                    end
                end
                ST_EXP_SQ: begin
                    if (mul_done) begin
                        x_r <= mul_res;
                        if (d_r[ptr_m1]) begin
                            state     <= ST_EXP_MUL;
                            mul_start <= 1'b1;
                        end else begin
                            ptr <= ptr_m1;
                            if (ptr_m1 == '0) state <= ST_TEST;
                            else              mul_start <= 1'b1;
                        end
                    end
                end
                ST_EXP_MUL: begin
                    if (mul_done) begin
                        x_r <= mul_res;
                        ptr <= ptr_m1;
                        if (ptr_m1 == '0) begin
                            state <= ST_TEST;
                        end else begin
                            state     <= ST_EXP_SQ;
                            mul_start <= 1'b1;
                        end
                    end
                end
                ST_TEST: begin
                    if (x_r == ONE || x_r == p_m1) begin
                        pp_r  <= 1'b1;
                        state <= ST_DONE;
                    end else if (r_r == R_WIDTH'(1)) begin
                        state <= ST_DONE;
                    end else begin
                        k_r       <= r_r - 1'b1;
                        state     <= ST_SQ_LOOP;
                        mul_start <= 1'b1;
                    end
                end
                ST_SQ_LOOP: begin
                    if (mul_done) begin
                        x_r <= mul_res;
                        if (mul_res == p_m1) begin
                            pp_r  <= 1'b1;
                            state <= ST_DONE;
                        end else if (mul_res == ONE || k_r == R_WIDTH'(1)) begin
                            // x = 1 without passing p-1, or squarings used up
                            state <= ST_DONE;
                        end else begin
                            k_r       <= k_r - 1'b1;
                            mul_start <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (out_ready) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef MR_CYCLE_COUNT_EN
    always_ff @(posedge aclk) begin
        if (areset) begin
            cycle_count <= '0;
        end else if (state == ST_IDLE) begin
            if (in_valid) cycle_count <= '0;
        end else if (state != ST_DONE && cycle_count != 32'hFFFF_FFFF) begin
            cycle_count <= cycle_count + 32'd1;
        end
    end
`endif

    assign in_ready       = (state == ST_IDLE);
    assign out_valid      = (state == ST_DONE);
    assign probable_prime = pp_r;
    assign bad_witness    = bad_r;
    assign d_value        = d_r;
    assign r_value        = r_r;
    assign state_dbg      = state;

endmodule
